// File: rtl/canny_pkg.sv
// canny_pkg: direction codes and scan FSM states shared by the Canny datapath blocks
package canny_pkg;
    localparam logic [1:0] BUF_HOLD  = 2'b00;
    localparam logic [1:0] BUF_RIGHT = 2'b01;
    localparam logic [1:0] BUF_LEFT  = 2'b10;
    localparam logic [1:0] BUF_DOWN  = 2'b11;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} scanStateType;
endpackage

// File: rtl/scan_address_gen.sv
// scan_address_gen: serpentine 9x9-window pixel-fetch request generator with scan-position flags
module scan_address_gen
    import canny_pkg::*;
#(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int WIN    = 9,
    parameter int X_W    = $clog2(IMG_W),
    parameter int Y_W    = $clog2(IMG_H),
    parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              enable9x9,
    input  logic [1:0]        gaussian_buffer,
    output logic              rd_valid,
    output logic              rd_kind,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [X_W-1:0]    rd_col,
    output logic [Y_W-1:0]    rd_row,
    output logic              readx_up_max,
    output logic              readx_down_min,
    output logic              ready_done,
    output logic              scan_busy,
    output logic              scan_err
);
    localparam logic [X_W-1:0] X_MAX   = X_W'(IMG_W-1);
    localparam logic [X_W-1:0] X_RCOL  = X_W'(IMG_W-WIN);
    localparam logic [X_W-1:0] X_RLEAD = X_W'(IMG_W-WIN-1);
    localparam logic [X_W-1:0] X_LLEAD = X_W'(WIN);
    localparam logic [Y_W-1:0] Y_LAST  = Y_W'(IMG_H-WIN);
    localparam logic [Y_W-1:0] Y_WIN   = Y_W'(WIN);

    scanStateType      state_q, state_d;
    logic [X_W-1:0]    lead_x_q, lead_x_d, rd_col_q, rd_col_d;
    logic [Y_W-1:0]    top_y_q, top_y_d, rd_row_q, rd_row_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              edge_q, edge_d, err_q, err_d;
    logic              rd_valid_q, rd_valid_d, rd_kind_q, rd_kind_d;
    logic              at_right, at_left;

    assign at_right  = lead_x_q == X_MAX;
    assign at_left   = lead_x_q == '0;
    assign rd_addr_d = ADDR_W'(rd_row_d) * ADDR_W'(IMG_W) + ADDR_W'(rd_col_d);

    always_comb begin
        state_d    = state_q;
        lead_x_d   = lead_x_q;
        top_y_d    = top_y_q;
        edge_d     = edge_q;
        err_d      = err_q;
        rd_valid_d = 1'b0;
        rd_kind_d  = rd_kind_q;
        rd_col_d   = rd_col_q;
        rd_row_d   = rd_row_q;
        if (start) begin
            state_d  = SCAN;
            lead_x_d = '0;
            top_y_d  = '0;
            edge_d   = 1'b0;
            err_d    = 1'b0;
        end else if (enable9x9) begin
            if (state_q != SCAN) begin
                err_d = 1'b1;
            end else if (gaussian_buffer == BUF_DOWN) begin
                if (!edge_q || top_y_q >= Y_LAST) begin
                    err_d = 1'b1;
                end else begin
                    rd_valid_d = 1'b1;
                    rd_kind_d  = 1'b1;
                    rd_row_d   = top_y_q + Y_WIN;
                    rd_col_d   = at_right ? X_RCOL : '0;
                    top_y_d    = top_y_q + Y_W'(1);
                    edge_d     = 1'b0;
                    lead_x_d   = at_right ? X_RLEAD : X_LLEAD;
                end
            end else if (edge_q) begin
                err_d = 1'b1;
            end else begin
                rd_valid_d = 1'b1;
                rd_kind_d  = 1'b0;
                rd_col_d   = lead_x_q;
                rd_row_d   = top_y_q;
                if (gaussian_buffer == BUF_LEFT) begin
                    lead_x_d = at_left ? lead_x_q : lead_x_q - X_W'(1);
                    edge_d   = at_left;
                    state_d  = (at_left && top_y_q == Y_LAST) ? DONE : SCAN;
                end else begin
                    lead_x_d = at_right ? lead_x_q : lead_x_q + X_W'(1);
                    edge_d   = at_right;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            lead_x_q   <= '0;
            top_y_q    <= '0;
            edge_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_kind_q  <= 1'b0;
            rd_col_q   <= '0;
            rd_row_q   <= '0;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            lead_x_q   <= lead_x_d;
            top_y_q    <= top_y_d;
            edge_q     <= edge_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_kind_q  <= rd_kind_d;
            rd_col_q   <= rd_col_d;
            rd_row_q   <= rd_row_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    assign rd_valid       = rd_valid_q;
    assign rd_kind        = rd_kind_q;
    assign rd_addr        = rd_addr_q;
    assign rd_col         = rd_col_q;
    assign rd_row         = rd_row_q;
    assign readx_up_max   = state_q != IDLE && at_right;
    assign readx_down_min = state_q != IDLE && at_left;
    assign ready_done     = state_q != IDLE && top_y_q == Y_LAST;
    assign scan_busy      = state_q == SCAN;
    assign scan_err       = err_q;
endmodule

// File: tb/tb_scan_address_gen.sv
// tb_scan_address_gen: scoreboard bench for the serpentine fetch generator on a 16x12 image
module tb_scan_address_gen;
    import canny_pkg::*;
    localparam int W = 16, H = 12, N = 9;

    typedef struct {int kind; int col; int row;} rd_t;

    logic       clk = 1'b0, n_rst = 1'b0, start = 1'b0, enable9x9 = 1'b0;
    logic [1:0] gaussian_buffer = BUF_HOLD;
    logic       rd_valid, rd_kind, readx_up_max, readx_down_min, ready_done, scan_busy, scan_err;
    logic [7:0] rd_addr;
    logic [3:0] rd_col, rd_row;

    int  n_tests = 0, n_fail = 0, cnt_col = 0, cnt_row = 0, last_addr = -1;
    rd_t exp_q[$];

    scan_address_gen #(.IMG_W(W), .IMG_H(H), .WIN(N)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .enable9x9(enable9x9),
        .gaussian_buffer(gaussian_buffer), .rd_valid(rd_valid), .rd_kind(rd_kind),
        .rd_addr(rd_addr), .rd_col(rd_col), .rd_row(rd_row),
        .readx_up_max(readx_up_max), .readx_down_min(readx_down_min),
        .ready_done(ready_done), .scan_busy(scan_busy), .scan_err(scan_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic e, input logic [1:0] g);
        @(negedge clk);
        start = s;
        enable9x9 = e;
        gaussian_buffer = g;
    endtask

    task automatic push(input int k, input int c, input int r);
        exp_q.push_back('{k, c, r});
    endtask

    function automatic int outs();
        return int'({rd_valid, rd_kind, rd_addr, rd_col, rd_row,
                     readx_up_max, readx_down_min, ready_done, scan_busy, scan_err});
    endfunction

    // Every request the DUT emits is matched against the oldest expected one.
    initial forever begin
        rd_t e;
        @(posedge clk);
        #1;
        if (rd_valid) begin
            if (exp_q.size() == 0) check("unexpected_rd", exp_q.size(), 1);
            else begin
                e = exp_q.pop_front();
                check("rd_kind", rd_kind, e.kind);
                check("rd_col", rd_col, e.col);
                check("rd_row", rd_row, e.row);
                check("rd_addr", rd_addr, e.row * W + e.col);
            end
            if (rd_kind) cnt_row++; else cnt_col++;
            last_addr = rd_addr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ex, ey, steps;
        bit right;
        // reset and IDLE behaviour
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (3) drive(0, 0, BUF_HOLD);
        check("reset_outs", outs(), 0);
        drive(0, 1, BUF_RIGHT);
        drive(0, 0, BUF_HOLD);
        check("idle_err", scan_err, 1);
        // first rightward run
        drive(1, 0, BUF_HOLD);
        for (int i = 0; i < W; i++) begin
            drive(0, 1, BUF_RIGHT);
            if (i == 0) check("start_busy_err", {scan_busy, scan_err}, 2);
            check("up_max", readx_up_max, int'(i == W - 1));
            push(0, i, 0);
        end
        drive(0, 1, BUF_RIGHT);
        drive(0, 0, BUF_HOLD);
        check("extra_right_err", scan_err, 1);
        check("up_max_hold", readx_up_max, 1);
        // turn at the right edge
        drive(0, 1, BUF_DOWN);
        push(1, 7, 9);
        drive(0, 1, BUF_LEFT);
        push(0, 6, 1);
        repeat (2) drive(0, 0, BUF_HOLD);
        check("pending_s3", exp_q.size(), 0);
        // full frame steered by the flags, as the controller would
        drive(1, 0, BUF_HOLD);
        cnt_col = 0; cnt_row = 0;
        ex = 0; ey = 0; right = 1; steps = 0;
        while (1) begin
            if (++steps > 100) begin check("frame_timeout", steps, 0); break; end
            drive(0, 1, right ? BUF_RIGHT : BUF_LEFT);
            push(0, ex, ey);
            if (right ? readx_up_max : readx_down_min) begin
                if (!right && ready_done) begin check("busy_last", scan_busy, 1); break; end
                drive(0, 1, BUF_DOWN);
                push(1, right ? W - N : 0, ey + N);
                ey++;
                ex = right ? W - N - 1 : N;
                right = !right;
            end else ex = right ? ex + 1 : ex - 1;
        end
        drive(0, 0, BUF_HOLD);
        check("done_flags", {scan_busy, ready_done, readx_down_min, scan_err}, 6);
        repeat (2) drive(0, 0, BUF_HOLD);
        check("col_reads", cnt_col, 37);
        check("row_reads", cnt_row, 3);
        check("last_addr", last_addr, 48);
        check("pending_s4", exp_q.size(), 0);
        drive(0, 1, BUF_DOWN);
        drive(0, 0, BUF_HOLD);
        check("done_down_err", scan_err, 1);
        // restart mid-scan with a coincident command
        drive(1, 0, BUF_HOLD);
        for (int i = 0; i < W; i++) begin drive(0, 1, BUF_RIGHT); push(0, i, 0); end
        drive(0, 1, BUF_DOWN); push(1, 7, 9);
        for (int i = 6; i >= 0; i--) begin drive(0, 1, BUF_LEFT); push(0, i, 1); end
        drive(0, 1, BUF_DOWN); push(1, 0, 10);
        drive(0, 0, BUF_HOLD);
        check("mid_top_y2", {ready_done, readx_down_min}, 0);
        drive(1, 1, BUF_RIGHT);
        drive(0, 0, BUF_HOLD);
        check("restart_state", {scan_err, readx_down_min, scan_busy}, 3);
        drive(0, 1, BUF_RIGHT); push(0, 0, 0);
        repeat (2) drive(0, 0, BUF_HOLD);
        check("pending_s5", exp_q.size(), 0);
        // asynchronous reset mid-run
        drive(1, 0, BUF_HOLD);
        for (int i = 0; i < 5; i++) begin drive(0, 1, BUF_RIGHT); push(0, i, 0); end
        drive(0, 1, BUF_RIGHT);
        #1 n_rst = 1'b0;
        #1 check("async_rst_outs", outs(), 0);
        drive(0, 0, BUF_HOLD);
        n_rst = 1'b1;
        drive(0, 1, BUF_RIGHT);
        drive(0, 0, BUF_HOLD);
        check("post_rst_state", {scan_busy, scan_err}, 1);
        drive(0, 0, BUF_HOLD);
        check("pending_end", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/scan_address_gen.md
# scan_address_gen

Pixel-fetch address generator that answers the Canny main controller's serpentine scan commands. It decodes `enable9x9` and the Gaussian buffer-direction code into image-SRAM read requests for the 9x9 window's leading column or new bottom row. It also produces the scan-position flags the controller branches on: `readx_up_max`, `readx_down_min` and `ready_done`. It sits between the main controller and the image-SRAM read port.

## Interface
Parameters:
- `IMG_W`, default 256: image width in pixels; must be greater than `WIN`.
- `IMG_H`, default 256: image height; `IMG_H-WIN` must be odd so the frame ends on a leftward run.
- `WIN`, default 9: window size.
- `X_W`, default `$clog2(IMG_W)`: column width.
- `Y_W`, default `$clog2(IMG_H)`: row width.
- `ADDR_W`, default `$clog2(IMG_W*IMG_H)`: address width.

Ports:
- `clk` in 1: clock.
- `n_rst` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle frame-start pulse.
- `enable9x9` in 1: fetch command strobe.
- `gaussian_buffer` in 2: direction code; 00/01 = RIGHT, 10 = LEFT, 11 = DOWN.
- `rd_valid` out 1: read request valid.
- `rd_kind` out 1: 0 = column read (`WIN` pixels, stride `IMG_W`); 1 = row read (`WIN` pixels, stride 1).
- `rd_addr` out `ADDR_W`: first pixel address, `rd_row*IMG_W + rd_col`.
- `rd_col` out `X_W`, `rd_row` out `Y_W`: coordinates of the first pixel.
- `readx_up_max` out 1, `readx_down_min` out 1, `ready_done` out 1: scan-position flags.
- `scan_busy` out 1: high in SCAN.
- `scan_err` out 1: sticky illegal-command flag.

## Operation
- Internal registers:
  - `lead_x`: leading column.
  - `top_y`: window top row.
  - `edge_done`: last column of the current run has been read.
  - FSM state: IDLE, SCAN, DONE.
- `start`, from any state:
  - `lead_x=0`, `top_y=0`, `edge_done=0`, `scan_err=0`, state goes to SCAN.
  - `start` overrides a coincident `enable9x9`; no read is issued that cycle.
- RIGHT command in SCAN:
  - If `edge_done=1`: set `scan_err`, issue no read.
  - Otherwise: column read at (`lead_x`, `top_y`).
  - Then `lead_x+1` if `lead_x<IMG_W-1`, else set `edge_done`.
- LEFT command in SCAN:
  - If `edge_done=1`: set `scan_err`, issue no read.
  - Otherwise: column read at (`lead_x`, `top_y`).
  - Then `lead_x-1` if `lead_x>0`, else set `edge_done`.
  - If this read is at `lead_x=0` and `top_y=IMG_H-WIN`: go to DONE.
- DOWN command in SCAN:
  - Legal only when `edge_done=1` and `top_y<IMG_H-WIN`; otherwise set `scan_err`, issue no read.
  - Row read at row `top_y+WIN`; start column `IMG_W-WIN` at the right edge, 0 at the left edge.
  - Then `top_y+1`, `edge_done=0`, and `lead_x` becomes `IMG_W-WIN-1` (right edge) or `WIN` (left edge).
- `enable9x9` in IDLE or DONE: set `scan_err`, issue no read.
- Flags, decoded from registers only, valid in SCAN and DONE, 0 in IDLE:
  - `readx_up_max` = (`lead_x==IMG_W-1`).
  - `readx_down_min` = (`lead_x==0`).
  - `ready_done` = (`top_y==IMG_H-WIN`).
- DONE holds until the next `start`.

## Timing
- `rd_*` outputs are registered: valid exactly 1 cycle after the command cycle; `rd_valid` is a one-cycle pulse per accepted command.
- Flags and `scan_busy` are Moore outputs and change the cycle after the updating edge.
- On entry to the last column's command cycle, the flag is already high, so the controller exits on the same edge. The flag then stays high through its hold state.
- Reset values: `rd_valid`, `rd_kind`, `rd_addr`, `rd_col`, `rd_row`, all flags, `scan_busy` and `scan_err` are 0; state is IDLE.
- An `n_rst` assertion mid-scan aborts immediately; no partial request is emitted.

## Structure
- Shared `canny_pkg` holds:
  - direction constants `BUF_HOLD=2'b00`, `BUF_RIGHT=2'b01`, `BUF_LEFT=2'b10`, `BUF_DOWN=2'b11`;
  - the `scanStateType` enum (IDLE, SCAN, DONE).
- Single module with no sub-module. The `rd_row*IMG_W` product is a constant-width multiply and needs no separate block.

## Test plan
All scenarios use `IMG_W=16`, `IMG_H=12`, `WIN=9`.
1. Reset, then 3 idle cycles -> every output 0; `enable9x9` pulse in IDLE -> `scan_err=1`, no `rd_valid`.
2. `start`, then 16 RIGHT commands -> `rd_addr` 0..15 with `rd_kind=0`; `readx_up_max` high during the 16th command cycle and after it; a 17th RIGHT -> `scan_err=1`, no read.
3. After scenario 2, DOWN -> `rd_kind=1`, `rd_row=9`, `rd_col=7`, `rd_addr=151`; the next LEFT reads col 6, row 1, `rd_addr=22`.
4. Full frame via the controller sequence -> 37 column reads and 3 row reads; the last read is col 0, row 3, `rd_addr=48`; `ready_done=1`; `scan_busy` falls the next cycle; DOWN in DONE -> `scan_err`.
5. `start` coincident with `enable9x9` at mid-scan `top_y=2` -> no read; counters cleared; next RIGHT gives `rd_addr=0`.
6. `n_rst` low mid-run at `lead_x=5` -> outputs 0 asynchronously; after release, the state is IDLE and a RIGHT command sets `scan_err`.
